dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that drives the DDS tuning inputs (`register_freq0`, `register_freq1`, `fselect`). It steps the output frequency linearly from a start value to a stop value, holding each frequency for a programmed dwell. Each next frequency is written into the inactive tuning register and then selected by toggling `fselect`, so the phase accumulator never sees a partially updated word. It sits between the register file and the DDS core.

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_dwell_timer.sv | 26 ++
 rtl/dds_sweep_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// dds_pkg: shared constants and state type for the DDS sweep controller.
// The DOWN state exists only when SWEEP_BIDIR_EN is defined.
package dds_pkg;
  localparam int FREQ_W_DEFAULT = 28;
  localparam int DWELL_MIN      = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DWELL     = 2'd1,
    LOAD_NEXT = 2'd2
`ifdef SWEEP_BIDIR_EN
    ,
    DOWN      = 2'd3
`endif
  } sweep_state_t;
endpackage
`default_nettype wire

// File: rtl/dds_dwell_timer.sv
`default_nettype none
// dds_dwell_timer: loadable down-counter that stops at zero and flags it.
module dds_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);
  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign zero = (count == '0);
endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// dds_sweep_ctrl: linear frequency sweep with ping-pong tuning registers.
// Define SWEEP_BIDIR_EN for an up/down (triangle) sweep via the DOWN state.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEFAULT,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  output logic [FREQ_W-1:0]  freq0_out,
  output logic [FREQ_W-1:0]  freq1_out,
  output logic               fselect_out,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               err
);
  sweep_state_t       state, state_n;
  logic [FREQ_W-1:0]  sh_start, sh_stop, sh_step, cur, nxt;
  logic [FREQ_W-1:0]  up_next, dir_next, turn_next, load_val;
  logic [DWELL_W-1:0] sh_dwell, cfg_dwell_eff;
  logic [FREQ_W:0]    sum;
  logic               sh_repeat, last, nxt_final;
  logic               up_final, dir_final, turn_final, turn_avail, load_final;
  logic               do_start, do_err, do_load, do_toggle, do_done, do_wrap;
  logic               write_inactive, dwell_zero;

  // One extra bit so cur+step cannot wrap past the top of the tuning range.
  assign sum           = {1'b0, cur} + {1'b0, sh_step};
  assign up_final      = (sum >= {1'b0, sh_stop});
  assign up_next       = up_final ? sh_stop : sum[FREQ_W-1:0];
  assign cfg_dwell_eff = (cfg_dwell < DWELL_W'(DWELL_MIN)) ? DWELL_W'(DWELL_MIN) : cfg_dwell;

`ifdef SWEEP_BIDIR_EN
  logic              down;
  logic [FREQ_W:0]   diff;
  logic              down_final;
  logic [FREQ_W-1:0] down_next;

  assign diff       = {1'b0, cur} - {1'b0, sh_step};
  assign down_final = diff[FREQ_W] || (diff <= {1'b0, sh_start}) || (sh_step == '0);
  assign down_next  = down_final ? sh_start : diff[FREQ_W-1:0];
  assign turn_avail = ~down;
  assign turn_next  = down_next;
  assign turn_final = down_final;
  assign dir_next   = down ? down_next : up_next;
  assign dir_final  = down ? down_final : up_final;
`else
  assign turn_avail = 1'b0;
  assign turn_next  = sh_start;
  assign turn_final = 1'b0;
  assign dir_next   = up_next;
  assign dir_final  = up_final;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n        = state;
    do_start       = 1'b0;
    do_err         = 1'b0;
    do_load        = 1'b0;
    do_toggle      = 1'b0;
    do_done        = 1'b0;
    do_wrap        = 1'b0;
    write_inactive = !last || turn_avail || sh_repeat;
    load_val       = sh_start;
    load_final     = (sh_step == '0) || (sh_start == sh_stop);
    if (!last) begin
      load_val   = dir_next;
      load_final = dir_final;
    end else if (turn_avail) begin
      load_val   = turn_next;
      load_final = turn_final;
    end

    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_start_freq <= cfg_stop_freq) begin
              do_start = 1'b1;
              state_n  = LOAD_NEXT;
            end else begin
              do_err = 1'b1;
            end
          end
        end
        LOAD_NEXT: begin
          do_load = 1'b1;
`ifdef SWEEP_BIDIR_EN
          state_n = down ? DOWN : DWELL;
`else
          state_n = DWELL;
`endif
        end
`ifdef SWEEP_BIDIR_EN
        DWELL, DOWN: begin
`else
        DWELL: begin
`endif
          if (dwell_zero) begin
            // Anything left to present (next step, turnaround or restart) means toggle.
            if (write_inactive) begin
              do_toggle = 1'b1;
              do_wrap   = last & ~turn_avail;
              state_n   = LOAD_NEXT;
            end else begin
              do_done = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq0_out   <= '0;
      freq1_out   <= '0;
      fselect_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap        <= 1'b0;
      err         <= 1'b0;
      sh_start    <= '0;
      sh_stop     <= '0;
      sh_step     <= '0;
      sh_dwell    <= '0;
      sh_repeat   <= 1'b0;
      cur         <= '0;
      nxt         <= '0;
      nxt_final   <= 1'b0;
      last        <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      down        <= 1'b0;
`endif
    end else begin
      busy <= (state_n != IDLE);
      done <= do_done;
      wrap <= do_wrap;
      err  <= do_err;
      if (do_start) begin
        sh_start    <= cfg_start_freq;
        sh_stop     <= cfg_stop_freq;
        sh_step     <= cfg_step;
        sh_dwell    <= cfg_dwell_eff;
        sh_repeat   <= cfg_repeat;
        freq0_out   <= cfg_start_freq;
        fselect_out <= 1'b0;
        cur         <= cfg_start_freq;
        last        <= (cfg_step == '0) || (cfg_start_freq == cfg_stop_freq);
      end
      if (do_load) begin
        nxt       <= load_val;
        nxt_final <= load_final;
        if (write_inactive) begin
          if (fselect_out) freq0_out <= load_val;
          else             freq1_out <= load_val;
        end
      end
      if (do_toggle) begin
        fselect_out <= ~fselect_out;
        cur         <= nxt;
        last        <= nxt_final;
      end
`ifdef SWEEP_BIDIR_EN
      // A turnaround sets down, a restart clears it; both equal turn_avail.
      if (do_start)               down <= 1'b0;
      else if (do_toggle && last) down <= turn_avail;
`endif
    end
  end

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (do_start | do_toggle),
    .load_val (do_start ? cfg_dwell_eff : sh_dwell),
    .zero     (dwell_zero)
  );
endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// tb_dds_sweep_ctrl: scoreboard bench; stimulus queues expected events, a monitor pops them.
module tb_dds_sweep_ctrl;
  localparam int FW = 28;
  localparam int DW = 16;
  localparam int EV_FREQ = 0;
  localparam int EV_DONE = 1;
  localparam int EV_WRAP = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int     kind;
    longint val;
    int     hold;
  } ev_t;

  ev_t exp_q[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_repeat = 1'b0;
  logic [FW-1:0] cfg_start_freq = '0;
  logic [FW-1:0] cfg_stop_freq = '0;
  logic [FW-1:0] cfg_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [FW-1:0] freq0_out, freq1_out;
  logic          fselect_out, busy, done, wrap, err;

  int n_checks = 0;
  int n_fail   = 0;

  dds_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_repeat     (cfg_repeat),
    .freq0_out      (freq0_out),
    .freq1_out      (freq1_out),
    .fselect_out    (fselect_out),
    .busy           (busy),
    .done           (done),
    .wrap           (wrap),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic pop_expect(input int kind, input longint act_val, output int hold);
    ev_t e;
    hold = 0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value 0x%0h, expected none", kind, act_val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_FREQ) check("freq_value", act_val, e.val);
      hold = e.hold;
    end
  endtask

  // Monitor: tracks each presented frequency as a segment between toggles.
  bit          seg_open = 0;
  bit          seg_changed = 0;
  int          seg_len = 0;
  int          seg_hold = 0;
  longint      seg_val = 0;
  logic        prev_fsel = 1'b0;

  always @(negedge clk) begin : mon
    logic [FW-1:0] act;
    bit            toggled;
    int            h;
    if (!rst_n) begin
      seg_open  = 0;
      prev_fsel = 1'b0;
    end else begin
      act     = fselect_out ? freq1_out : freq0_out;
      toggled = seg_open && busy && (fselect_out != prev_fsel);
      if (seg_open && (toggled || !busy)) begin
        if (toggled || done) check("hold_cycles", seg_len, seg_hold);
        check("active_word_stable", seg_changed, 0);
        seg_open = 0;
      end else if (seg_open) begin
        seg_len++;
        if (act != seg_val) seg_changed = 1;
      end
      if (err) begin
        pop_expect(EV_ERR, 0, h);
        check("err_busy_low", busy, 0);
      end
      if (wrap) pop_expect(EV_WRAP, 0, h);
      if (done) pop_expect(EV_DONE, 0, h);
      if (busy && !seg_open) begin
        pop_expect(EV_FREQ, act, h);
        seg_open    = 1;
        seg_len     = 1;
        seg_val     = act;
        seg_hold    = h;
        seg_changed = 0;
      end
      prev_fsel = fselect_out;
    end
  end

  // Reference: list of frequencies from start toward stop, clamped at stop.
  task automatic model_sweep(input longint s, input longint e, input longint st, input int hold);
    longint f;
    f = s;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back('{EV_FREQ, f, hold});
      if (st == 0 || f >= e) break;
      f = (f + st >= e) ? e : f + st;
    end
  endtask

  function automatic int eff_hold(input int dw);
    return ((dw < 1) ? 1 : dw) + 1;
  endfunction

  task automatic drive_cfg(input longint s, input longint e, input longint st, input int dw, input bit rep);
    cfg_start_freq = FW'(s);
    cfg_stop_freq  = FW'(e);
    cfg_step       = FW'(st);
    cfg_dwell      = DW'(dw);
    cfg_repeat     = rep;
  endtask

  task automatic scramble_cfg();
    cfg_start_freq = FW'($urandom);
    cfg_stop_freq  = FW'($urandom);
    cfg_step       = FW'($urandom);
    cfg_dwell      = DW'($urandom);
    cfg_repeat     = 1'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic check_all_zero();
    check("rst_freq0", freq0_out, 0);
    check("rst_freq1", freq1_out, 0);
    check("rst_fsel", fselect_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_err", err, 0);
  endtask

  task automatic run_sweep(input longint s, input longint e, input longint st, input int dw);
    int     hold;
    longint second;
    hold = eff_hold(dw);
    model_sweep(s, e, st, hold);
    exp_q.push_back('{EV_DONE, 0, 0});
    @(negedge clk);
    drive_cfg(s, e, st, dw, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    #1;
    check("busy_after_start", busy, 1);
    check("freq0_first", freq0_out, s);
    check("fsel_first", fselect_out, 0);
    @(negedge clk);
    #1;
    if (st != 0 && s < e) begin
      second = (s + st >= e) ? e : s + st;
      check("freq1_second", freq1_out, second);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("sweep_complete", 2000);
  endtask

  task automatic run_err(input longint s, input longint e);
    logic [FW-1:0] f0, f1;
    logic          fs;
    exp_q.push_back('{EV_ERR, 0, 0});
    @(negedge clk);
    drive_cfg(s, e, 1, 1, 1'b0);
    f0 = freq0_out;
    f1 = freq1_out;
    fs = fselect_out;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_freq0_held", freq0_out, f0);
    check("err_freq1_held", freq1_out, f1);
    check("err_fsel_held", fselect_out, fs);
    @(negedge clk);
    #1;
    check("err_single_cycle", err, 0);
    check("err_queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_repeat_abort(input longint s, input longint e, input longint st, input int dw);
    int            hold, n, q0;
    logic [FW-1:0] f0, f1;
    logic          fs;
    hold = eff_hold(dw);
    q0 = exp_q.size();
    model_sweep(s, e, st, hold);
    n = exp_q.size() - q0;
    exp_q.push_back('{EV_WRAP, 0, 0});
    model_sweep(s, e, st, hold);
    exp_q.push_back('{EV_WRAP, 0, 0});
    exp_q.push_back('{EV_FREQ, s, hold});
    @(negedge clk);
    drive_cfg(s, e, st, dw, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2 * n * hold + 1; i++) @(negedge clk);
    abort = 1'b1;
    f0 = freq0_out;
    f1 = freq1_out;
    fs = fselect_out;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_freq0_held", freq0_out, f0);
    check("abort_freq1_held", freq1_out, f1);
    check("abort_fsel_held", fselect_out, fs);
    check("abort_no_done", done, 0);
    repeat (6) @(negedge clk);
    #1;
    check("repeat_events_consumed", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint s, span, st;
    int     dw;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero();
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(28'h0001000, 28'h0004000, 28'h0001000, 3);
    run_sweep(28'h0000000, 28'h0000500, 28'h0000200, 0);
    run_sweep(28'hFFFFF00, 28'hFFFFFFF, 28'h0000200, 1);
    run_sweep(28'h0000050, 28'h0000100, 0, 2);
    run_err(28'h0003000, 28'h0002000);

    // abort together with start while idle: nothing may start
    @(negedge clk);
    drive_cfg(28'h100, 28'h200, 28'h80, 1, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("abort_start_idle_busy", busy, 0);
    check("abort_start_idle_err", err, 0);

    run_repeat_abort(28'h0000100, 28'h0000300, 28'h0000100, 2);

    // asynchronous reset in the middle of a sweep
    model_sweep(28'h1000, 28'h4000, 28'h1000, 4);
    exp_q.push_back('{EV_DONE, 0, 0});
    @(negedge clk);
    drive_cfg(28'h1000, 28'h4000, 28'h1000, 3, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(28'h0002000, 28'h0002800, 28'h0000300, 2);

    for (int r = 0; r < 6; r++) begin
      span = $urandom_range(0, 4000);
      s    = $urandom_range(0, 32'(28'hFFFFFFF - span));
      st   = span / $urandom_range(1, 6) + $urandom_range(0, 3);
      dw   = $urandom_range(0, 4);
      run_sweep(s, s + span, st, dw);
    end
    for (int r = 0; r < 2; r++) begin
      s = $urandom_range(1, 28'hFFFFFFF);
      run_err(s, $urandom_range(0, 32'(s - 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
